// File: rtl/alu_mc_if.sv
// Operand/result bundle between the register-read stage and alu_mc.
// The master presents operands; the slave (the ALU) returns results and flags.
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       fn;
    logic [WIDTH-1:0] op_A;
    logic [WIDTH-1:0] op_B;
    logic             cin;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             co;
    logic             z;
    logic             n;
    logic             v;
    logic             dz;

    modport master (
        output in_valid, fn, op_A, op_B, cin,
        input  in_ready, done, out, out_hi, co, z, n, v, dz
    );

    modport slave (
        input  in_valid, fn, op_A, op_B, cin,
        output in_ready, done, out, out_hi, co, z, n, v, dz
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: legacy add/sub/logic ops, shifts, SLT in one cycle;
// iterative unsigned multiply and restoring divide over WIDTH cycles.
//
// state  | meaning
// S_IDLE | ready for operands; single-cycle ops complete from here
// S_RUN  | MULU/DIVU iterating, one step per cycle, cnt_q 0..WIDTH-1
module alu_mc #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             is_div_q;

    logic [WIDTH-1:0] out_q, out_hi_q;
    logic             co_q, z_q, n_q, v_q, dz_q, done_q;

    logic             ready;
    logic             accept;
    logic             is_mc;
    logic             last;

    logic [SW-1:0]    sh;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] sc_out, sc_hi;
    logic             sc_co, sc_v, sc_dz;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] it_hi, it_lo;

    assign accept = bus.in_valid && (state_q == S_IDLE);
    assign is_mc  = (bus.fn == 4'd12) || ((bus.fn == 4'd13) && (bus.op_B != '0));
    assign last   = (state_q == S_RUN) && (cnt_q == SW'(WIDTH - 1));
    assign sh     = bus.op_B[SW-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid && is_mc) state_d = S_RUN;
            end
            S_RUN: begin
                if (last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle results; add/sub carry is bit WIDTH of the WIDTH+1 bit sum.
    always_comb begin
        wide   = '0;
        sc_out = '0;
        sc_hi  = '0;
        sc_co  = 1'b0;
        sc_v   = 1'b0;
        sc_dz  = 1'b0;
        case (bus.fn)
            4'd0, 4'd1: begin
                wide   = {1'b0, bus.op_A} + {1'b0, bus.op_B} + {{WIDTH{1'b0}}, bus.cin};
                sc_out = wide[MSB:0];
                sc_co  = wide[WIDTH];
                sc_v   = (bus.op_A[MSB] == bus.op_B[MSB]) && (wide[MSB] != bus.op_A[MSB]);
            end
            4'd2, 4'd3: begin
                wide   = {1'b0, bus.op_A} - {1'b0, bus.op_B} + {{WIDTH{1'b0}}, bus.cin};
                sc_out = wide[MSB:0];
                sc_co  = wide[WIDTH];
                sc_v   = (bus.op_A[MSB] != bus.op_B[MSB]) && (wide[MSB] != bus.op_A[MSB]);
            end
            4'd4:  sc_out = bus.op_A & bus.op_B;
            4'd5:  sc_out = bus.op_A | bus.op_B;
            4'd6:  sc_out = bus.op_A ^ bus.op_B;
            4'd7:  sc_out = ~(bus.op_A & bus.op_B);
            4'd8:  sc_out = bus.op_A << sh;
            4'd9:  sc_out = bus.op_A >> sh;
            4'd10: sc_out = $signed(bus.op_A) >>> sh;
            4'd11: sc_out = {{(WIDTH-1){1'b0}}, ($signed(bus.op_A) < $signed(bus.op_B))};
            4'd13: begin
                sc_out = '1;
                sc_hi  = bus.op_A;
                sc_dz  = 1'b1;
            end
            default: sc_out = '0;
        endcase
    end

    // One multiply or divide step. {hi_q,lo_q} is the shared product / remainder:quotient pair.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[MSB]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[MSB:0] - b_q;
        if (is_div_q) begin
            it_hi = div_ge ? div_diff : div_shift[MSB:0];
            it_lo = {lo_q[MSB-1:0], div_ge};
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], lo_q[MSB:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            out_q    <= '0;
            out_hi_q <= '0;
            co_q     <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (is_mc) begin
                    a_q      <= bus.op_A;
                    b_q      <= bus.op_B;
                    is_div_q <= (bus.fn == 4'd13);
                    hi_q     <= '0;
                    lo_q     <= (bus.fn == 4'd13) ? bus.op_A : bus.op_B;
                    cnt_q    <= '0;
                end else begin
                    out_q    <= sc_out;
                    out_hi_q <= sc_hi;
                    co_q     <= sc_co;
                    v_q      <= sc_v;
                    dz_q     <= sc_dz;
                    z_q      <= (sc_out == '0);
                    n_q      <= sc_out[MSB];
                    done_q   <= 1'b1;
                end
            end else if (state_q == S_RUN) begin
                hi_q  <= it_hi;
                lo_q  <= it_lo;
                cnt_q <= cnt_q + 1'b1;
                if (last) begin
                    out_q    <= it_lo;
                    out_hi_q <= it_hi;
                    co_q     <= !is_div_q && (it_hi != '0);
                    v_q      <= 1'b0;
                    dz_q     <= 1'b0;
                    z_q      <= (it_lo == '0);
                    n_q      <= it_lo[MSB];
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.done     = done_q;
    assign bus.out      = out_q;
    assign bus.out_hi   = out_hi_q;
    assign bus.co       = co_q;
    assign bus.z        = z_q;
    assign bus.n        = n_q;
    assign bus.v        = v_q;
    assign bus.dz       = dz_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=8: arithmetic reference model plus per-cycle compare,
// and directed vectors with literal expectations.
module tb_alu_mc;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    typedef struct {
        int out;
        int hi;
        int co;
        int z;
        int n;
        int v;
        int dz;
    } res_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int x);
        return (x & (1 << (W - 1))) != 0 ? x - (1 << W) : x;
    endfunction

    function automatic res_t calc(input int fn, input int a, input int b, input int cin);
        res_t r;
        int   t;
        int   sh;
        r  = '{0, 0, 0, 0, 0, 0, 0};
        sh = b % W;
        case (fn)
            0, 1: begin
                t     = a + b + cin;
                r.out = t & MASK;
                r.co  = (t >> W) & 1;
                r.v   = (sx(a) < 0) == (sx(b) < 0) && (sx(r.out) < 0) != (sx(a) < 0);
            end
            2, 3: begin
                t     = (a - b + cin) & ((1 << (W + 1)) - 1);
                r.out = t & MASK;
                r.co  = (t >> W) & 1;
                r.v   = (sx(a) < 0) != (sx(b) < 0) && (sx(r.out) < 0) != (sx(a) < 0);
            end
            4:  r.out = a & b;
            5:  r.out = a | b;
            6:  r.out = a ^ b;
            7:  r.out = ~(a & b) & MASK;
            8:  r.out = (a << sh) & MASK;
            9:  r.out = a >> sh;
            10: r.out = (sx(a) >>> sh) & MASK;
            11: r.out = (sx(a) < sx(b)) ? 1 : 0;
            12: begin
                t     = a * b;
                r.out = t & MASK;
                r.hi  = t >> W;
                r.co  = (r.hi != 0);
            end
            13: begin
                if (b == 0) begin
                    r.out = MASK;
                    r.hi  = a;
                    r.dz  = 1;
                end else begin
                    r.out = a / b;
                    r.hi  = a % b;
                end
            end
            default: r.out = 0;
        endcase
        r.z = (r.out == 0);
        r.n = (r.out >> (W - 1)) & 1;
        return r;
    endfunction

    // Reference model: what the outputs must be during the cycle after each edge.
    res_t exp_r;
    res_t pend_r;
    int   pend_cnt;
    bit   exp_ready;
    bit   exp_done;
    bit   started;

    initial begin
        exp_r     = '{0, 0, 0, 0, 0, 0, 0};
        pend_r    = '{0, 0, 0, 0, 0, 0, 0};
        pend_cnt  = 0;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        started   = 1'b0;
    end

    always @(posedge clk) begin
        bit acc;
        int f;
        int a;
        int b;
        if (rst) begin
            exp_r     = '{0, 0, 0, 0, 0, 0, 0};
            pend_cnt  = 0;
            exp_ready = 1'b1;
            exp_done  = 1'b0;
            started   = 1'b1;
        end else begin
            acc      = bus.in_valid && exp_ready;
            exp_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    exp_r     = pend_r;
                    exp_done  = 1'b1;
                    exp_ready = 1'b1;
                end
            end
            if (acc) begin
                f = int'(bus.fn);
                a = int'(bus.op_A);
                b = int'(bus.op_B);
                if (f == 12 || (f == 13 && b != 0)) begin
                    pend_r    = calc(f, a, b, int'(bus.cin));
                    pend_cnt  = W;
                    exp_ready = 1'b0;
                end else begin
                    exp_r    = calc(f, a, b, int'(bus.cin));
                    exp_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", int'(bus.in_ready), int'(exp_ready));
            chk("done",     int'(bus.done),     int'(exp_done));
            chk("out",      int'(bus.out),      exp_r.out);
            chk("out_hi",   int'(bus.out_hi),   exp_r.hi);
            chk("co",       int'(bus.co),       exp_r.co);
            chk("z",        int'(bus.z),        exp_r.z);
            chk("n",        int'(bus.n),        exp_r.n);
            chk("v",        int'(bus.v),        exp_r.v);
            chk("dz",       int'(bus.dz),       exp_r.dz);
        end
    end

    task automatic send(input int f, input int a, input int b, input int c);
        bus.in_valid = 1'b1;
        bus.fn       = 4'(f);
        bus.op_A     = W'(a);
        bus.op_B     = W'(b);
        bus.cin      = c[0];
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!bus.done && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        res_t r;
        int   n;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.fn       = '0;
        bus.op_A     = '0;
        bus.op_B     = '0;
        bus.cin      = 1'b0;

        // Pin the model against hand-computed values.
        r = calc(0, 8, 5, 1);     chk("model_add", r.out, 14);
        r = calc(3, 8, 23, 0);    chk("model_sub", r.out, 'hF1); chk("model_sub_co", r.co, 1);
        r = calc(12, 16, 16, 0);  chk("model_mul_hi", r.hi, 1);
        r = calc(13, 200, 7, 0);  chk("model_div", r.out, 28);  chk("model_rem", r.hi, 4);
        r = calc(10, 'h90, 3, 0); chk("model_sra", r.out, 'hF2);
        r = calc(2, 'h80, 1, 0);  chk("model_ovf", r.v, 1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out", int'(bus.out), 0);
        chk("rst_ready", int'(bus.in_ready), 1);

        send(0, 8, 5, 1);
        chk("add_out", int'(bus.out), 14); chk("add_done", int'(bus.done), 1);
        send(0, 8, 5, 0);
        chk("add0_out", int'(bus.out), 13);

        send(3, 8, 23, 0);
        chk("sub_out", int'(bus.out), 'hF1); chk("sub_co", int'(bus.co), 1);
        chk("sub_n", int'(bus.n), 1);        chk("sub_v", int'(bus.v), 0);
        send(7, 8, 23, 0);
        chk("nand_out", int'(bus.out), 'hFF); chk("nand_co", int'(bus.co), 0);
        chk("nand_done", int'(bus.done), 1);

        send(12, 16, 16, 0);
        chk("mul_busy", int'(bus.in_ready), 0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.fn = 4'd0; bus.op_A = 8'd3; bus.op_B = 8'd4;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(20, n);
        chk("mul_latency", n, 6);
        chk("mul_out", int'(bus.out), 0); chk("mul_hi", int'(bus.out_hi), 1);
        chk("mul_co", int'(bus.co), 1);   chk("mul_z", int'(bus.z), 1);

        send(13, 200, 7, 0);
        wait_done(20, n);
        chk("div_latency", n, 8);
        chk("div_q", int'(bus.out), 28); chk("div_r", int'(bus.out_hi), 4);
        send(13, 200, 0, 0);
        chk("dz_out", int'(bus.out), 'hFF); chk("dz_hi", int'(bus.out_hi), 200);
        chk("dz_flag", int'(bus.dz), 1);    chk("dz_ready", int'(bus.in_ready), 1);

        send(10, 'h90, 3, 0);  chk("sra_out", int'(bus.out), 'hF2);
        send(11, 'h80, 1, 0);  chk("slt_out", int'(bus.out), 1);
        send(8, 1, 'h0A, 0);   chk("sll_out", int'(bus.out), 4);
        send(2, 'h80, 1, 0);   chk("ovf_v", int'(bus.v), 1);
        send(14, 'h55, 'h0F, 1);
        chk("rsv_out", int'(bus.out), 0); chk("rsv_z", int'(bus.z), 1);

        send(12, 15, 17, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", int'(bus.in_ready), 1);
        chk("rst_mid_done", int'(bus.done), 0);
        chk("rst_mid_out", int'(bus.out), 0);
        repeat (10) @(negedge clk);
        send(12, 15, 17, 0);
        wait_done(20, n);
        chk("mul2_latency", n, 8);
        chk("mul2_out", int'(bus.out), 'hFF); chk("mul2_hi", int'(bus.out_hi), 0);
        send(9, 'hF0, 4, 0);   chk("srl_out", int'(bus.out), 'h0F);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the MIPS datapath. It keeps the legacy 8-function combinational ALU opcode set and adds shifts, signed compare, an iterative unsigned multiply and an iterative unsigned divide. Operands are accepted with a valid/ready handshake, results and flags are registered, and the block sits between the register-read stage and write-back. The datapath stalls on `in_ready` while a multi-cycle operation is running.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and `fn` are presented this cycle.
- `in_ready`  out  1  block can accept operands this cycle.
- `fn`  in  4  operation select.
- `op_A`, `op_B`  in  WIDTH  operands.
- `cin`  in  1  carry-in, used by the add/sub codes only.
- `done`  out  1  one-cycle pulse: `out`, `out_hi` and the flags are new.
- `out`  out  WIDTH  result, low word.
- `out_hi`  out  WIDTH  MUL high word or DIV remainder; 0 for other ops.
- `co`, `z`, `n`, `v`, `dz`  out  1 each  carry, zero, negative, signed overflow, divide-by-zero.

## Operation
- **Accept:** a transfer happens when `in_valid && in_ready`. `fn`, `op_A`, `op_B` and `cin` are captured on that edge; later input changes have no effect on the operation.
- **States:**
  - IDLE: `in_ready` = 1.
  - RUN: `in_ready` = 0; a cycle counter runs 0..WIDTH-1.
  - IDLE→RUN on accepting MUL or DIV with a nonzero divisor. All other accepts finish in IDLE.
  - RUN→IDLE when the counter reaches WIDTH-1.
- **Ignored input:** `in_valid` while in RUN is ignored and nothing is queued.
- **Add/sub, `fn` 0 to 3** (legacy-compatible; all arithmetic is WIDTH+1 bits):
  - 0 and 1: `{co,out}` = cin + A + B.
  - 2 and 3: `{co,out}` = (cin + A − B) mod 2^(WIDTH+1).
  - For add, `v` = A[MSB]==B[MSB] && out[MSB]!=A[MSB].
  - For sub, `v` = A[MSB]!=B[MSB] && out[MSB]!=A[MSB].
- **Logic, `fn` 4 to 7:** 4 AND, 5 OR, 6 XOR, 7 NAND.
- **Shifts and compare** (shift amount = B[log2(WIDTH)-1:0]):
  - 8 SLL, 9 SRL, 10 SRA.
  - 11 SLT: `out` = 1 if signed A < signed B, else 0.
- **12 MULU:** unsigned shift-add over WIDTH iterations, giving {out_hi,out} = A × B. `co` = (out_hi != 0).
- **13 DIVU:** restoring division over WIDTH iterations; `out` = quotient, `out_hi` = remainder. If B == 0: no RUN, `out` = all ones, `out_hi` = A, `dz` = 1.
- **14 and 15:** reserved; `out` = 0 and the flags follow the general rules below.
- **Flag rules:**
  - `z` = (out == 0) and `n` = out[MSB], for every op.
  - `co` = 0 for everything except add/sub/MULU.
  - `v` = 0 for everything except add/sub.
  - `dz` = 0 for everything except DIVU with B == 0.
  - `out_hi` = 0 for everything except MULU/DIVU.
- **Hold:** outputs and flags hold their values until the next `done`.
- **Reset:** `rst` wins over everything, including mid-RUN. State returns to IDLE, the counter clears, the partial result is discarded and no `done` is produced. Reset values:
  - `out`, `out_hi`, `co`, `z`, `n`, `v`, `dz`, `done` = 0.
  - `in_ready` = 1 in the cycle after reset.

## Timing
- **Single-cycle ops** (`fn` 0–11, 14, 15, and DIVU by zero): accept at edge N, then `done` = 1 and results valid during cycle N+1. `in_ready` stays 1, so throughput is one op per cycle back-to-back.
- **MULU / DIVU:** accept at edge N. `in_ready` = 0 for cycles N+1 to N+WIDTH. `done` and results arrive in cycle N+WIDTH+1, and `in_ready` = 1 in that same cycle, so a new accept can coincide with `done`.
- **Done pulse:** `done` is high for exactly one cycle per accepted operation.

## Test plan
All scenarios use WIDTH=8.
- **ADD:** fn=0, A=8, B=5, cin=1 → next cycle `out`=14, `co`=0, `z`=0, `done`=1. Repeat with cin=0 → `out`=13.
- **SUB and NAND, back-to-back:**
  - fn=3, A=8, B=23, cin=0 → `out`=0xF1, `co`=1, `n`=1, `v`=0.
  - Immediately follow with fn=7, A=8, B=23 → `out`=0xFF, `co`=0.
  - Both `done` pulses land on consecutive cycles.
- **MULU:**
  - 16×16 → `done` at N+9 with `out`=0x00, `out_hi`=0x01, `co`=1, `z`=1.
  - `in_ready`=0 for N+1..N+8.
  - `in_valid` pulses during N+3 are ignored.
- **DIVU:**
  - 200/7 → `out`=28, `out_hi`=4 at N+9.
  - 200/0 → `out`=0xFF, `out_hi`=200, `dz`=1 at N+1.
- **Shift and compare:**
  - SRA with A=0x90, B=3 → `out`=0xF2.
  - SLT with A=0x80, B=1 → `out`=1.
  - SLL with A=1, B=0x0A → shift amount 2 → `out`=4.
- **Reset mid-MULU:**
  - Accept 15×17, assert `rst` at N+4 → no `done`, all outputs 0, `in_ready`=1 at N+5.
  - A new 15×17 then yields `out`=0xFF, `out_hi`=0.
